// File: rtl/sign_narrow_stream.sv
// sign_narrow_stream
//
// Narrows a stream of IN_W-bit signed words to OUT_W bits. This is the
// streaming inverse of a sign extender. A word fits when the bits it loses
// are all copies of the OUT_W sign bit. A word that does not fit is flagged
// on out_ovf and counted in a saturating overflow counter.
//
// Build option:
//   SIGN_NARROW_SAT_EN  defined   : an overflowing word saturates by its sign
//                                   (max positive or min negative).
//                       undefined : an overflowing word is truncated to its
//                                   low OUT_W bits.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   upstream word present
//   in_ready   block can accept a word this cycle
//   in_data    IN_W-bit signed input word
//   out_valid  narrowed word present
//   out_ready  downstream accepts out_data this cycle
//   out_data   OUT_W-bit narrowed signed word
//   out_ovf    out_data came from an overflowing input
//   ovf_clr    clear the overflow counter
//   ovf_count  overflowing words accepted, saturating at all-ones
//
// Storage is a main output register plus one skid register. in_ready depends
// only on registered state, so there is no combinational path from out_ready
// back to in_ready.

module sign_narrow_stream #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // True when every bit from the OUT_W sign bit upward agrees.
    function automatic logic word_fits(input logic signed [IN_W-1:0] w);
        logic [IN_W-OUT_W:0] hi;
        hi = w[IN_W-1:OUT_W-1];
        return (&hi) | ~(|hi);
    endfunction

    function automatic logic signed [OUT_W-1:0] narrow_word(
        input logic signed [IN_W-1:0] w,
        input logic                   fits
    );
        logic signed [OUT_W-1:0] res;
        res = w[OUT_W-1:0];
        if (!fits) begin
`ifdef SIGN_NARROW_SAT_EN
            res = w[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                            : {1'b0, {(OUT_W-1){1'b1}}};
`else
            res = w[OUT_W-1:0];
`endif
        end
        return res;
    endfunction

    logic signed [IN_W-1:0]  in_word;
    logic                    in_fits;
    logic signed [OUT_W-1:0] in_narrow;
    logic                    accept;
    logic                    out_fire;

    logic                    out_valid_q,  out_valid_d;
    logic signed [OUT_W-1:0] out_data_q,   out_data_d;
    logic                    out_ovf_q,    out_ovf_d;
    logic                    skid_valid_q, skid_valid_d;
    logic signed [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic                    skid_ovf_q,   skid_ovf_d;
    logic [CNT_W-1:0]        ovf_count_q,  ovf_count_d;

    assign in_word   = in_data;
    assign in_fits   = word_fits(in_word);
    assign in_narrow = narrow_word(in_word, in_fits);

    assign in_ready  = !skid_valid_q && !reset;
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ovf_d    = out_ovf_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ovf_d   = skid_ovf_q;

        if (out_fire) begin
            if (skid_valid_q) begin
                // accept cannot happen here: in_ready is low while skid holds a word
                out_data_d   = skid_data_q;
                out_ovf_d    = skid_ovf_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_data_d = in_narrow;
                out_ovf_d  = !in_fits;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = in_narrow;
                out_ovf_d   = !in_fits;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_narrow;
                skid_ovf_d   = !in_fits;
            end
        end
    end

    // Clear wins over the old value, but an overflow accepted in the same
    // cycle still counts, so the counter lands on 1.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_clr) begin
            ovf_count_d = (accept && !in_fits) ? CNT_ONE : '0;
        end else if (accept && !in_fits && ovf_count_q != CNT_MAX) begin
            ovf_count_d = ovf_count_q + CNT_ONE;
        end
    end

    // ---- register stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ovf_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ovf_q    <= out_ovf_d;
            skid_valid_q <= skid_valid_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    // Skid payload is qualified by skid_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
        skid_ovf_q  <= skid_ovf_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_sign_narrow_stream.sv
module tb_sign_narrow_stream;

    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             ovf_clr;
    logic [CNT_W-1:0] ovf_count;

    sign_narrow_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [OUT_W:0] sb[$];
    logic [CNT_W-1:0] model_cnt = '0;
    bit   mon_en    = 1'b0;
    bit   hold_prev = 1'b0;
    logic [OUT_W:0] prev_out;
    bit   rnd_done  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference narrowing: does the word lie in the OUT_W signed range?
    function automatic logic [OUT_W:0] ref_narrow(input logic [IN_W-1:0] w);
        logic signed [IN_W-1:0] sv;
        sv = w;
        if (sv > 127 || sv < -128) begin
`ifdef SIGN_NARROW_SAT_EN
            return {1'b1, (w[IN_W-1] ? 8'h80 : 8'h7F)};
`else
            return {1'b1, w[7:0]};
`endif
        end
        return {1'b0, w[7:0]};
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [OUT_W:0] e;
        logic acc_ovf;
        if (mon_en) begin
            if (reset) begin
                sb.delete();
                model_cnt = '0;
                hold_prev = 1'b0;
                chk("in_ready_in_reset", 64'(in_ready), 64'd0);
            end else begin
                chk("ovf_count", 64'(ovf_count), 64'(model_cnt));
                if (hold_prev) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", 64'({out_ovf, out_data}), 64'(prev_out));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %0h, expected no word at %0t",
                                 {out_ovf, out_data}, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("out_word", 64'({out_ovf, out_data}), 64'(e));
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev_out  = {out_ovf, out_data};
                acc_ovf = 1'b0;
                if (in_valid && in_ready) begin
                    e = ref_narrow(in_data);
                    sb.push_back(e);
                    acc_ovf = e[OUT_W];
                end
                if (ovf_clr) model_cnt = acc_ovf ? 2'd1 : 2'd0;
                else if (acc_ovf && model_cnt != 2'd3) model_cnt = model_cnt + 2'd1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; leaves in_valid high.
    task automatic send(input logic [IN_W-1:0] w);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            step();
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got no accept, expected accept of %0h", w);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [IN_W-1:0] rand_word();
        logic [7:0] b;
        b = 8'($urandom);
        case ($urandom_range(0, 3))
            0: return {{24{b[7]}}, b};
            1: return 32'($urandom);
            2: case ($urandom_range(0, 3))
                   0: return 32'h0000007F;
                   1: return 32'h00000080;
                   2: return 32'hFFFFFF80;
                   default: return 32'hFFFFFF7F;
               endcase
            default: return {{24{b[7]}}, b} ^ (32'h1 << $urandom_range(8, 31));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; ovf_clr = 1'b0;
        step(); step();
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_ovf", 64'(out_ovf), 64'd0);
        chk("reset_ovf_count", 64'(ovf_count), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;
        step();

        // Boundary words that fit, 1-cycle latency.
        send(32'h0000007F);
        chk("fit_pos_valid", 64'(out_valid), 64'd1);
        chk("fit_pos_data", 64'({out_ovf, out_data}), 64'h07F);
        send(32'hFFFFFF80);
        chk("fit_neg_data", 64'({out_ovf, out_data}), 64'h080);
        idle(2);
        chk("fit_ovf_count", 64'(ovf_count), 64'd0);

        // Just-overflowing words.
        send(32'h00000080);
`ifdef SIGN_NARROW_SAT_EN
        chk("ovf_pos_data", 64'({out_ovf, out_data}), 64'h17F);
`else
        chk("ovf_pos_data", 64'({out_ovf, out_data}), 64'h180);
`endif
        send(32'hFFFFFF7F);
`ifdef SIGN_NARROW_SAT_EN
        chk("ovf_neg_data", 64'({out_ovf, out_data}), 64'h180);
`else
        chk("ovf_neg_data", 64'({out_ovf, out_data}), 64'h17F);
`endif
        idle(2);
        chk("ovf_count_two", 64'(ovf_count), 64'd2);

        // Backpressure: A to main, B to skid, C held off.
        out_ready = 1'b0;
        send(32'h00000011);
        send(32'hFFFFFFF0);
        in_data = 32'h00000033;
        for (int i = 0; i < 3; i++) step();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_main", 64'({out_valid, out_ovf, out_data}), 64'h211);
        out_ready = 1'b1;
        send(32'h00000033);
        idle(4);
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Saturating counter with CNT_W=2.
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_count", 64'(ovf_count), 64'd0);
        send(32'h12345678); chk("cnt_1", 64'(ovf_count), 64'd1);
        send(32'h80000000); chk("cnt_2", 64'(ovf_count), 64'd2);
        send(32'h00000100); chk("cnt_3", 64'(ovf_count), 64'd3);
        send(32'hFFFF0000); chk("cnt_sat_a", 64'(ovf_count), 64'd3);
        send(32'h7FFFFFFF); chk("cnt_sat_b", 64'(ovf_count), 64'd3);
        ovf_clr = 1'b1;
        send(32'h00000200);
        ovf_clr = 1'b0;
        chk("clr_with_ovf", 64'(ovf_count), 64'd1);
        idle(3);

        // Reset with main and skid both full.
        out_ready = 1'b0;
        send(32'h00001000);
        send(32'h00000005);
        idle(1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_count", 64'(ovf_count), 64'd0);
        chk("mid_reset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        idle(5);

        // Random traffic against the reference model.
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    ovf_clr = ($urandom_range(0, 19) == 0);
                    send(rand_word());
                end
                ovf_clr = 1'b0;
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    step();
                end
            end
        join
        out_ready = 1'b1;
        idle(10);
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
